// File: rtl/isqrt_pkg.sv
// rtl/isqrt_pkg.sv - shared types and sizing helpers for the sequential integer square root
// Contents: state_e FSM encoding, root_w() root width, cnt_w() iteration counter width.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Root width is always half the radicand width.
  function automatic int root_w(input int width);
    return width / 2;
  endfunction

  // Counter runs ROOT_W-1 down to 0.
  function automatic int cnt_w(input int width);
    return $clog2(width / 2);
  endfunction

endpackage

// File: rtl/isqrt_seq_if.sv
// rtl/isqrt_seq_if.sv - operand/result handshake bundle for isqrt_seq
// master: drives x_in, x_ready; observes busy, y_out, r_out, y_ready.
// slave : the root unit; samples x_in, x_ready; drives busy, y_out, r_out, y_ready.
interface isqrt_seq_if #(parameter int WIDTH = 8);
  import isqrt_pkg::*;

  localparam int ROOT_W = root_w(WIDTH);

  logic [WIDTH-1:0]  x_in;
  logic              x_ready;
  logic              busy;
  logic [ROOT_W-1:0] y_out;
  logic [ROOT_W:0]   r_out;
  logic              y_ready;

  modport master (
    output x_in, x_ready,
    input  busy, y_out, r_out, y_ready
  );

  modport slave (
    input  x_in, x_ready,
    output busy, y_out, r_out, y_ready
  );

endinterface

// File: rtl/isqrt_step.sv
// rtl/isqrt_step.sv - one combinational digit of the square-root recurrence
// Inputs : rem_i (partial remainder), root_i (partial root), bits_i (next two radicand bits).
// Outputs: rem_o (next partial remainder), bit_o (next root bit).
module isqrt_step #(
  parameter int ROOT_W = 4
) (
  input  logic [ROOT_W+1:0] rem_i,
  input  logic [ROOT_W-1:0] root_i,
  input  logic [1:0]        bits_i,
  output logic [ROOT_W+1:0] rem_o,
  output logic              bit_o
);

  logic [ROOT_W+1:0] shifted;
  logic [ROOT_W+1:0] trial;
  logic              unused_rem_hi;

  // The incoming remainder never exceeds 2*root, so its top two bits are
  // zero and drop out when the next two radicand bits are shifted in.
  assign shifted       = {rem_i[ROOT_W-1:0], bits_i};
  assign unused_rem_hi = ^rem_i[ROOT_W+1:ROOT_W];

  // The true trial value lies strictly inside +/-2^(ROOT_W+1), so the
  // wrap-around subtraction at this width yields a correct sign bit.
  assign trial = shifted - {root_i, 2'b01};
  assign bit_o = ~trial[ROOT_W+1];
  assign rem_o = bit_o ? trial : shifted;

endmodule

// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - sequential integer square root, one root bit per clock
// Ports: clk, rst (async, active high), bus (isqrt_seq_if.slave: x_in, x_ready,
//        busy, y_out, r_out, y_ready).
// Option: ISQRT_ROUND_EN makes y_out round-to-nearest (saturating); r_out stays the floor remainder.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  isqrt_seq_if.slave  bus
);

  localparam int ROOT_W = root_w(WIDTH);
  localparam int CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(ROOT_W - 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("isqrt_seq: WIDTH must be even and at least 4");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  rad_q, rad_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [ROOT_W+1:0] rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ROOT_W-1:0] y_q, y_d;
  logic [ROOT_W:0]   r_q, r_d;

  logic [ROOT_W+1:0] step_rem;
  logic              step_bit;
  logic [ROOT_W-1:0] root_next;
  logic [ROOT_W-1:0] y_fin;

  isqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (rad_q[WIDTH-1 -: 2]),
    .rem_o  (step_rem),
    .bit_o  (step_bit)
  );

  assign root_next = {root_q[ROOT_W-2:0], step_bit};

`ifdef ISQRT_ROUND_EN
  // Round up when the remainder exceeds the floor root, i.e. x > y^2 + y.
  always_comb begin
    y_fin = root_next;
    if (step_rem > {2'b00, root_next} && root_next != '1) begin
      y_fin = root_next + ROOT_W'(1);
    end
  end
`else
  assign y_fin = root_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    r_d     = r_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.x_ready) begin
          rad_d   = bus.x_in;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        rad_d  = {rad_q[WIDTH-3:0], 2'b00};
        rem_d  = step_rem;
        root_d = root_next;
        if (cnt_q == '0) begin
          y_d     = y_fin;
          r_d     = step_rem[ROOT_W:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q == CALC);
  assign bus.y_ready = (state_q == DONE);
  assign bus.y_out   = y_q;
  assign bus.r_out   = r_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// tb/tb_isqrt_seq.sv - scoreboard bench for isqrt_seq at WIDTH=8 and WIDTH=16
module tb_isqrt_seq;

  typedef struct {
    int y;
    int r;
    int due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q8[$];
  exp_t q16[$];
  int   last8_y = 0, last8_r = 0;
  int   last16_y = 0, last16_r = 0;

  isqrt_seq_if #(.WIDTH(8))  i8 ();
  isqrt_seq_if #(.WIDTH(16)) i16 ();

  isqrt_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8.slave));
  isqrt_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: largest y with y*y <= x, remainder x - y*y, optional rounding.
  function automatic exp_t model(input longint unsigned x, input int rw, input int due);
    exp_t e;
    longint unsigned s = 0;
    while ((s + 1) * (s + 1) <= x) s++;
    e.y   = int'(s);
    e.r   = int'(x - s * s);
    e.due = due;
`ifdef ISQRT_ROUND_EN
    if (e.r > e.y && e.y < (1 << rw) - 1) e.y = e.y + 1;
`endif
    return e;
  endfunction

  // Waits until the unit can accept, presents x, and records the expected result.
  task automatic send(input bit w16, input int x, input bit keep);
    int n = 0;
    @(negedge clk);
    while ((w16 ? i16.busy : i8.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", n, 0);
    if (w16) begin
      i16.x_in    = x[15:0];
      i16.x_ready = 1'b1;
      q16.push_back(model(longint'(x[15:0]), 8, cyc + 1 + 8));
    end else begin
      i8.x_in    = x[7:0];
      i8.x_ready = 1'b1;
      q8.push_back(model(longint'(x[7:0]), 4, cyc + 1 + 4));
    end
    @(negedge clk);
    chk(w16 ? "busy_after_start16" : "busy_after_start8", w16 ? i16.busy : i8.busy, 1);
    if (!keep) begin
      if (w16) i16.x_ready = 1'b0;
      else     i8.x_ready  = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last8_y = 0;
      last8_r = 0;
    end else if (i8.y_ready) begin
      chk("busy_in_done8", i8.busy, 0);
      if (q8.size() == 0) begin
        chk("unexpected_pulse8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("y8", i8.y_out, e.y);
        chk("r8", i8.r_out, e.r);
        chk("latency8", cyc, e.due);
        last8_y = e.y;
        last8_r = e.r;
      end
    end else begin
      chk("hold_y8", i8.y_out, last8_y);
      chk("hold_r8", i8.r_out, last8_r);
      if (q8.size() > 0 && cyc > q8[0].due) begin
        chk("missed_pulse8", cyc, q8[0].due);
        void'(q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last16_y = 0;
      last16_r = 0;
    end else if (i16.y_ready) begin
      chk("busy_in_done16", i16.busy, 0);
      if (q16.size() == 0) begin
        chk("unexpected_pulse16", 1, 0);
      end else begin
        e = q16.pop_front();
        chk("y16", i16.y_out, e.y);
        chk("r16", i16.r_out, e.r);
        chk("latency16", cyc, e.due);
        last16_y = e.y;
        last16_r = e.r;
      end
    end else begin
      chk("hold_y16", i16.y_out, last16_y);
      chk("hold_r16", i16.r_out, last16_r);
      if (q16.size() > 0 && cyc > q16[0].due) begin
        chk("missed_pulse16", cyc, q16[0].due);
        void'(q16.pop_front());
      end
    end
  end

  initial begin
    int n;
    bit k;
    rst = 1'b1;
    i8.x_in = '0;  i8.x_ready = 1'b0;
    i16.x_in = '0; i16.x_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy8", i8.busy, 0);
    chk("reset_y_ready8", i8.y_ready, 0);
    chk("reset_y8", i8.y_out, 0);
    chk("reset_r8", i8.r_out, 0);
    chk("reset_busy16", i16.busy, 0);
    chk("reset_y16", i16.y_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Boundaries and rounding cases.
    send(0, 0, 0);
    send(0, 255, 0);
    send(0, 210, 0);
    send(0, 211, 0);
    send(0, 203, 0);

    // Abort mid-CALC: outputs clear immediately and the operand never completes.
    send(0, 203, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", i8.busy, 0);
    chk("abort_y", i8.y_out, 0);
    chk("abort_r", i8.r_out, 0);
    chk("abort_y_ready", i8.y_ready, 0);
    q8.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);

    send(0, 203, 0);

    // Back-to-back with x_ready held high.
    send(0, 100, 1);
    send(0, 99, 1);
    send(0, 1, 0);

    // Start during CALC is dropped.
    send(0, 144, 0);
    i8.x_in    = 8'd50;
    i8.x_ready = 1'b1;
    @(negedge clk);
    i8.x_ready = 1'b0;

    send(1, 65535, 0);
    send(1, 40000, 0);
    send(1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      k = (i != 39) && ($urandom_range(0, 1) == 1);
      send(0, int'($urandom_range(0, 255)), k);
      if (!k) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 25; i++) begin
      k = (i != 24) && ($urandom_range(0, 1) == 1);
      send(1, int'($urandom_range(0, 65535)), k);
      if (!k) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((q8.size() > 0 || q16.size() > 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain8", q8.size(), 0);
    chk("drain16", q16.size(), 0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
